fifo_sel_rd_ctrl: RTL

//  Consumer side of the FIFO-select handshake: takes the 8-bit select code from the

---
 rtl/fifo_sel_rd_ctrl_pkg.sv | 25 ++
 rtl/fifo_sel_rd_ctrl_stall_timer.sv | 30 +++
 rtl/fifo_sel_rd_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fifo_sel_rd_ctrl_pkg.sv
// Shared select-code layout and read-controller state encoding.
package fifo_sel_rd_ctrl_pkg;

  localparam int SEL_W         = 8;
  localparam int SEL_VALID_BIT = 7;
  localparam int SEL_IDX_W     = 7;

  localparam logic [SEL_W-1:0] NON_FIFO_CHOOSE = 8'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    DONE = 2'd3
  } rd_state_t;

  function automatic logic sel_valid(input logic [SEL_W-1:0] code);
    return code[SEL_VALID_BIT];
  endfunction

  function automatic logic [SEL_IDX_W-1:0] sel_idx(input logic [SEL_W-1:0] code);
    return code[SEL_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/fifo_sel_rd_ctrl_stall_timer.sv
// Counts consecutive empty cycles; expire is combinational on the STALL_MAX-th one.
// Clear has priority; the counter self-clears on expiry.
module rd_stall_timer #(
  parameter int STALL_MAX = 255
) (
  input  logic glb_clk,
  input  logic glb_areset_n,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CW = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of earlier empty cycles, so the current one is cnt+1
  assign expire = count_en && (cnt == CW'(STALL_MAX - 1));

  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      cnt <= '0;
    end else if (clear || expire) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_sel_rd_ctrl.sv
// Drains one length-prefixed packet from the arbiter-selected show-ahead FIFO per select code.
// Zero-latency mux/pop; out_ready low simply holds the word, only an empty FIFO arms the stall abort.
module fifo_sel_rd_ctrl
  import fifo_sel_rd_ctrl_pkg::*;
#(
  parameter int PORT_NUM  = 4,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int STALL_MAX = 255
) (
  input  logic                       glb_clk,
  input  logic                       glb_areset_n,
  input  logic [SEL_W-1:0]           fifo_sel_code,
  input  logic [PORT_NUM*DATA_W-1:0] fifo_dout,
  input  logic [PORT_NUM-1:0]        fifo_empty,
  output logic [PORT_NUM-1:0]        fifo_rd_en,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [SEL_IDX_W-1:0]       out_port,
  output logic                       busy,
  output logic                       pkt_done,
  output logic                       err_abort,
  output logic                       err_badsel,
  output logic [15:0]                pkt_cnt
);

  localparam logic [SEL_IDX_W-1:0] PORT_LIMIT = SEL_IDX_W'(PORT_NUM);

  rd_state_t            state, state_nxt;
  logic [SEL_IDX_W-1:0] idx;
  logic [LEN_W-1:0]     cnt;
  logic [LEN_W-1:0]     hdr_len;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_empty;
  logic                 active;
  logic                 xfer;
  logic                 stall_expire;
  logic [SEL_IDX_W-1:0] code_idx;
  logic                 code_ok;
  logic                 code_bad;

  assign code_idx = sel_idx(fifo_sel_code);
  assign code_ok  = sel_valid(fifo_sel_code) && (code_idx <  PORT_LIMIT);
  assign code_bad = sel_valid(fifo_sel_code) && (code_idx >= PORT_LIMIT);

  // Compare-based mux keeps the 7-bit index from over-indexing the port vectors
  always_comb begin
    sel_empty = 1'b1;
    sel_data  = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (idx == SEL_IDX_W'(p)) begin
        sel_empty = fifo_empty[p];
        sel_data  = fifo_dout[p*DATA_W +: DATA_W];
      end
    end
  end

  assign active    = (state == HDR) || (state == PAY);
  assign busy      = (state != IDLE);
  assign out_valid = active && !sel_empty;
  assign xfer      = out_valid && out_ready;
  assign out_data  = active ? sel_data : '0;
  assign out_port  = idx;
  assign hdr_len   = sel_data[LEN_W-1:0];

  always_comb begin
    fifo_rd_en = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      fifo_rd_en[p] = xfer && (idx == SEL_IDX_W'(p));
    end
  end

  rd_stall_timer #(
    .STALL_MAX (STALL_MAX)
  ) u_stall_timer (
    .glb_clk      (glb_clk),
    .glb_areset_n (glb_areset_n),
    .clear        (!active || !sel_empty),
    .count_en     (active && sel_empty),
    .expire       (stall_expire)
  );

  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    out_sop    = 1'b0;
    out_eop    = 1'b0;
    pkt_done   = 1'b0;
    err_abort  = 1'b0;
    err_badsel = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_sel_code != NON_FIFO_CHOOSE) begin
          if (code_ok) begin
            state_nxt = HDR;
          end else if (code_bad) begin
            err_badsel = 1'b1;
          end
        end
      end
      HDR: begin
        out_sop = 1'b1;
        out_eop = out_valid && (hdr_len == '0);
        if (stall_expire) begin
          err_abort = 1'b1;
          state_nxt = IDLE;
        end else if (xfer) begin
          state_nxt = (hdr_len == '0) ? DONE : PAY;
        end
      end
      PAY: begin
        out_eop = (cnt == LEN_W'(1));
        if (stall_expire) begin
          err_abort = 1'b1;
          state_nxt = IDLE;
        end else if (xfer && (cnt == LEN_W'(1))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        pkt_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Index is captured only in IDLE, so code changes mid-packet cannot redirect the drain
  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      idx <= '0;
    end else if ((state == IDLE) && code_ok) begin
      idx <= code_idx;
    end
  end

  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      cnt <= '0;
    end else if (xfer) begin
      if (state == HDR) begin
        cnt <= hdr_len;
      end else if (state == PAY) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      pkt_cnt <= '0;
    end else if ((state == DONE) && (pkt_cnt != 16'hFFFF)) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

endmodule
